// File: rtl/enigma_stepper.sv
// rtl/enigma_stepper.sv - Enigma keypress sequencer: rotor stepping with double step, settle delay, letter presentation.
// One keypress walks IDLE -> STEP -> SETTLE (SETTLE_CYCLES) -> PRESENT -> IDLE.
module enigma_stepper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [4:0]  key_letter,
  output logic        key_ready,
  input  logic [1:0]  cfg_l,
  input  logic [1:0]  cfg_m,
  input  logic [1:0]  cfg_r,
  output logic        rotate_l,
  output logic        rotate_m,
  output logic        rotate_r,
  output logic [4:0]  pos_l,
  output logic [4:0]  pos_m,
  output logic [4:0]  pos_r,
  output logic [25:0] letter_onehot,
  output logic        letter_valid,
  output logic        bad_key
);

  typedef enum logic [1:0] {IDLE, STEP, SETTLE, PRESENT} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  letter_q, letter_d;
  logic [2:0]  rot_q, rot_d;
  logic [4:0]  pos_l_q, pos_l_d;
  logic [4:0]  pos_m_q, pos_m_d;
  logic [4:0]  pos_r_q, pos_r_d;
  logic        bad_q, bad_d;
  logic        accept;
  logic        mid_notch;

  function automatic logic at_notch(input logic [1:0] rtype, input logic [4:0] pos);
    case (rtype)
      2'b00:   at_notch = (pos == 5'd16);
      2'b01:   at_notch = (pos == 5'd4);
      2'b10:   at_notch = (pos == 5'd21);
      default: at_notch = 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] pos);
    inc26 = (pos == 5'd25) ? 5'd0 : pos + 5'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      letter_q <= 5'd0;
      rot_q    <= 3'b000;
      pos_l_q  <= 5'd0;
      pos_m_q  <= 5'd0;
      pos_r_q  <= 5'd0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      letter_q <= letter_d;
      rot_q    <= rot_d;
      pos_l_q  <= pos_l_d;
      pos_m_q  <= pos_m_d;
      pos_r_q  <= pos_r_d;
      bad_q    <= bad_d;
    end
  end

  assign accept = (state_q == IDLE) && key_valid && (key_letter <= 5'd25);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    if (accept) state_d = STEP;
      STEP: begin
        state_d = SETTLE;
        cnt_d   = 4'd0;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = PRESENT;
        else                      cnt_d   = cnt_q + 4'd1;
      end
      PRESENT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rotate decisions are taken at acceptance from the live cfg and the pre-step
  // positions, so later cfg changes cannot reach the keypress in flight.
  always_comb begin
    mid_notch = at_notch(cfg_m, pos_m_q);
    letter_d  = accept ? key_letter : letter_q;
    rot_d     = accept ? {mid_notch, mid_notch | at_notch(cfg_r, pos_r_q), 1'b1} : 3'b000;
    bad_d     = (state_q == IDLE) && key_valid && (key_letter > 5'd25);
    pos_l_d   = rot_q[2] ? inc26(pos_l_q) : pos_l_q;
    pos_m_d   = rot_q[1] ? inc26(pos_m_q) : pos_m_q;
    pos_r_d   = rot_q[0] ? inc26(pos_r_q) : pos_r_q;
  end

  always_comb begin
    key_ready     = (state_q == IDLE);
    letter_valid  = (state_q == PRESENT);
    letter_onehot = (state_q == PRESENT) ? (26'd1 << letter_q) : 26'd0;
  end

  assign rotate_l = rot_q[2];
  assign rotate_m = rot_q[1];
  assign rotate_r = rot_q[0];
  assign pos_l    = pos_l_q;
  assign pos_m    = pos_m_q;
  assign pos_r    = pos_r_q;
  assign bad_key  = bad_q;

endmodule

// File: tb/tb_enigma_stepper.sv
// tb/tb_enigma_stepper.sv - Self-checking bench for enigma_stepper against a rotor-arithmetic model.
module tb_enigma_stepper;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [4:0]  key_letter = 5'd0;
  logic        key_ready;
  logic [1:0]  cfg_l = 2'b11, cfg_m = 2'b11, cfg_r = 2'b11;
  logic        rotate_l, rotate_m, rotate_r;
  logic [4:0]  pos_l, pos_m, pos_r;
  logic [25:0] letter_onehot;
  logic        letter_valid;
  logic        bad_key;

  int cmp_count = 0;
  int fail_count = 0;
  int ml, mm, mr;

  enigma_stepper #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_letter(key_letter),
    .key_ready(key_ready), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_r(cfg_r),
    .rotate_l(rotate_l), .rotate_m(rotate_m), .rotate_r(rotate_r),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
    .letter_onehot(letter_onehot), .letter_valid(letter_valid), .bad_key(bad_key)
  );

  always #5 clk = ~clk;

  function automatic int notch(input int rtype);
    case (rtype)
      0: return 16;
      1: return 4;
      2: return 21;
      default: return -1;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    key_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ml = 0; mm = 0; mr = 0;
  endtask

  task automatic press_key(input logic [4:0] letter, input logic [1:0] cl, input logic [1:0] cm,
                           input logic [1:0] cr, output logic [2:0] rot_seen);
    int n;
    logic el, em;
    logic [25:0] exp_oh;
    n = 0;
    while (key_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    cmp_count++;
    if (key_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL ready_wait: key_ready got %b want 1", key_ready);
    end
    el = (mm == notch(int'(cm)));
    em = (mr == notch(int'(cr))) || el;
    key_valid = 1'b1; key_letter = letter; cfg_l = cl; cfg_m = cm; cfg_r = cr;
    @(negedge clk);
    key_valid = 1'b0;
    cfg_l = 2'($urandom_range(0, 3)); cfg_m = 2'($urandom_range(0, 3)); cfg_r = 2'($urandom_range(0, 3));
    rot_seen = {rotate_l, rotate_m, rotate_r};
    cmp_count++;
    if (rot_seen !== {el, em, 1'b1} || bad_key !== 1'b0) begin
      fail_count++;
      $display("FAIL step_pulse: rot/bad got %b/%b want %b/0", rot_seen, bad_key, {el, em, 1'b1});
    end
    mr = (mr + 1) % 26;
    if (em) mm = (mm + 1) % 26;
    if (el) ml = (ml + 1) % 26;
    for (int i = 0; i < S; i++) begin
      @(negedge clk);
      cmp_count++;
      if ({rotate_l, rotate_m, rotate_r, letter_valid, key_ready} !== 5'b0 || letter_onehot !== 26'd0) begin
        fail_count++;
        $display("FAIL settle_quiet: rot/lv/rdy got %b onehot %h want 0", {rotate_l, rotate_m, rotate_r, letter_valid, key_ready}, letter_onehot);
      end
    end
    @(negedge clk);
    exp_oh = 26'd1 << letter;
    cmp_count++;
    if (letter_valid !== 1'b1 || letter_onehot !== exp_oh || key_ready !== 1'b0) begin
      fail_count++;
      $display("FAIL present: lv %b onehot %h rdy %b want 1 %h 0", letter_valid, letter_onehot, key_ready, exp_oh);
    end
    @(negedge clk);
    cmp_count++;
    if (key_ready !== 1'b1 || letter_valid !== 1'b0 || {pos_l, pos_m, pos_r} !== {5'(ml), 5'(mm), 5'(mr)}) begin
      fail_count++;
      $display("FAIL back_to_idle: rdy %b lv %b pos %0d/%0d/%0d want 1 0 %0d/%0d/%0d", key_ready, letter_valid, pos_l, pos_m, pos_r, ml, mm, mr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_valid = 1'b1; key_letter = 5'd0;
    repeat (3) @(negedge clk);
    cmp_count++;
    if ({rotate_l, rotate_m, rotate_r, letter_valid, bad_key} !== 5'b0 || letter_onehot !== 26'd0 || {pos_l, pos_m, pos_r} !== 15'd0) begin
      fail_count++;
      $display("FAIL reset_values: rot/lv/bad %b onehot %h pos %h want all 0", {rotate_l, rotate_m, rotate_r, letter_valid, bad_key}, letter_onehot, {pos_l, pos_m, pos_r});
    end
    reset = 1'b0; key_valid = 1'b0;
    ml = 0; mm = 0; mr = 0;
    @(negedge clk);
    cmp_count++;
    if (key_ready !== 1'b1 || rotate_r !== 1'b0) begin
      fail_count++;
      $display("FAIL post_reset_ready: rdy %b rot_r %b want 1 0", key_ready, rotate_r);
    end
  endtask

  task automatic test_single_key();
    logic [2:0] rs;
    do_reset();
    press_key(5'd0, 2'b00, 2'b00, 2'b00, rs);
    cmp_count++;
    if (rs !== 3'b001 || {pos_l, pos_m, pos_r} !== {5'd0, 5'd0, 5'd1}) begin
      fail_count++;
      $display("FAIL single_key: rot %b pos %0d/%0d/%0d want 001 0/0/1", rs, pos_l, pos_m, pos_r);
    end
  endtask

  task automatic test_turnover();
    logic [2:0] rs;
    do_reset();
    for (int k = 1; k <= 22; k++) press_key(5'(k % 26), 2'b11, 2'b11, 2'b10, rs);
    cmp_count++;
    if (rs !== 3'b011 || {pos_l, pos_m, pos_r} !== {5'd0, 5'd1, 5'd22}) begin
      fail_count++;
      $display("FAIL turnover: rot %b pos %0d/%0d/%0d want 011 0/1/22", rs, pos_l, pos_m, pos_r);
    end
  endtask

  task automatic test_double_step();
    logic [2:0] rs;
    do_reset();
    for (int k = 1; k <= 100; k++) press_key(5'($urandom_range(0, 25)), 2'b00, 2'b01, 2'b10, rs);
    cmp_count++;
    if ({pos_l, pos_m, pos_r} !== {5'd0, 5'd4, 5'd22}) begin
      fail_count++;
      $display("FAIL press_100: pos %0d/%0d/%0d want 0/4/22", pos_l, pos_m, pos_r);
    end
    press_key(5'd25, 2'b00, 2'b01, 2'b10, rs);
    cmp_count++;
    if (rs !== 3'b111 || {pos_l, pos_m, pos_r} !== {5'd1, 5'd5, 5'd23}) begin
      fail_count++;
      $display("FAIL double_step: rot %b pos %0d/%0d/%0d want 111 1/5/23", rs, pos_l, pos_m, pos_r);
    end
  endtask

  task automatic test_bad_key();
    int n;
    do_reset();
    cfg_l = 2'b11; cfg_m = 2'b11; cfg_r = 2'b11;
    key_valid = 1'b1; key_letter = 5'd27;
    @(negedge clk);
    key_valid = 1'b0;
    cmp_count++;
    if (bad_key !== 1'b1 || {rotate_l, rotate_m, rotate_r} !== 3'b0 || key_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL bad_key_pulse: bad %b rot %b rdy %b want 1 000 1", bad_key, {rotate_l, rotate_m, rotate_r}, key_ready);
    end
    @(negedge clk);
    cmp_count++;
    if (bad_key !== 1'b0 || {pos_l, pos_m, pos_r} !== 15'd0 || rotate_r !== 1'b0) begin
      fail_count++;
      $display("FAIL bad_key_clear: bad %b pos %h rot_r %b want 0 0 0", bad_key, {pos_l, pos_m, pos_r}, rotate_r);
    end
    key_valid = 1'b1; key_letter = 5'd3;
    @(negedge clk);
    key_letter = 5'd5;
    cmp_count++;
    if (rotate_r !== 1'b1) begin
      fail_count++;
      $display("FAIL held_first: rot_r got %b want 1", rotate_r);
    end
    for (int c = 2; c <= S + 2; c++) begin
      @(negedge clk);
      cmp_count++;
      if (rotate_r !== 1'b0 || letter_valid !== (c == S + 2) || (c == S + 2 && letter_onehot !== 26'd8)) begin
        fail_count++;
        $display("FAIL held_ignored: cycle %0d rot_r %b lv %b onehot %h", c, rotate_r, letter_valid, letter_onehot);
      end
    end
    @(negedge clk);
    cmp_count++;
    if (key_ready !== 1'b1 || rotate_r !== 1'b0) begin
      fail_count++;
      $display("FAIL held_idle: rdy %b rot_r %b want 1 0", key_ready, rotate_r);
    end
    @(negedge clk);
    key_valid = 1'b0;
    cmp_count++;
    if (rotate_r !== 1'b1) begin
      fail_count++;
      $display("FAIL held_second: rot_r got %b want 1", rotate_r);
    end
    n = 0;
    while (key_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    mr = 2;
    cmp_count++;
    if (key_ready !== 1'b1 || {pos_l, pos_m, pos_r} !== {5'd0, 5'd0, 5'd2}) begin
      fail_count++;
      $display("FAIL held_final: rdy %b pos %0d/%0d/%0d want 1 0/0/2", key_ready, pos_l, pos_m, pos_r);
    end
  endtask

  task automatic test_reset_abort();
    logic seen;
    do_reset();
    cfg_l = 2'b00; cfg_m = 2'b00; cfg_r = 2'b00;
    key_valid = 1'b1; key_letter = 5'd7;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ml = 0; mm = 0; mr = 0;
    cmp_count++;
    if (key_ready !== 1'b1 || {pos_l, pos_m, pos_r} !== 15'd0) begin
      fail_count++;
      $display("FAIL abort_state: rdy %b pos %h want 1 0", key_ready, {pos_l, pos_m, pos_r});
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | letter_valid | rotate_l | rotate_m | rotate_r;
    end
    cmp_count++;
    if (seen !== 1'b0 || key_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL abort_quiet: activity %b rdy %b want 0 1", seen, key_ready);
    end
  endtask

  task automatic test_wrap();
    logic [2:0] rs;
    logic any_m;
    do_reset();
    any_m = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      press_key(5'($urandom_range(0, 25)), 2'($urandom_range(0, 3)), 2'b11, 2'b11, rs);
      any_m = any_m | rs[1];
      if (k == 26) begin
        cmp_count++;
        if (pos_r !== 5'd0) begin
          fail_count++;
          $display("FAIL wrap_26: pos_r got %0d want 0", pos_r);
        end
      end
    end
    cmp_count++;
    if (pos_r !== 5'd4 || any_m !== 1'b0) begin
      fail_count++;
      $display("FAIL wrap_end: pos_r %0d rotate_m seen %b want 4 0", pos_r, any_m);
    end
  endtask

  task automatic test_random();
    logic [2:0] rs;
    do_reset();
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        key_valid = 1'b1; key_letter = 5'($urandom_range(26, 31));
        @(negedge clk);
        key_valid = 1'b0;
        cmp_count++;
        if (bad_key !== 1'b1 || rotate_r !== 1'b0) begin
          fail_count++;
          $display("FAIL random_bad: bad %b rot_r %b want 1 0", bad_key, rotate_r);
        end
        @(negedge clk);
      end
      press_key(5'($urandom_range(0, 25)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), rs);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_single_key();
    test_turnover();
    test_double_step();
    test_bad_key();
    test_reset_abort();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
